// File: rtl/id_decode_pkg.sv
// Shared types for the instruction decode stage: opcode constants, control
// enums and the registered decode payload handed to execute.
package id_decode_pkg;

    // Payload datapath fields are sized for the widest supported XLEN and zero-extended.
    localparam int DATA_W = 64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } aluop_t;

    typedef enum logic [3:0] {
        CF_NONE = 4'd0, CF_BEQ, CF_BNE, CF_BLT, CF_BGE, CF_BLTU, CF_BGEU, CF_JAL, CF_JALR
    } cfuop_t;

    typedef enum logic [1:0] {OPA_RS1 = 2'd0, OPA_PC, OPA_ZERO} opr_a_sel_t;
    typedef enum logic       {OPB_RS2 = 1'b0, OPB_IMM} opr_b_sel_t;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM, WB_PC4} wb_sel_t;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] opr_a;
        logic [DATA_W-1:0] opr_b;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc4;
        aluop_t            aluop;
        cfuop_t            cfuop;
        logic              rf_en;
        logic              dm_en;
        opr_a_sel_t        opr_a_sel;
        opr_b_sel_t        opr_b_sel;
        wb_sel_t           wb_sel;
        logic              illegal;
    } id_out_t;

    // sub_en selects SUB for funct3=000 (register form only); sra_en selects SRA for funct3=101.
    function automatic aluop_t alu_op_decode(input logic [2:0] f3, input logic sub_en,
                                             input logic sra_en);
        case (f3)
            3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic cfuop_t branch_decode(input logic [2:0] f3);
        case (f3)
            3'b000:  return CF_BEQ;
            3'b001:  return CF_BNE;
            3'b100:  return CF_BLT;
            3'b101:  return CF_BGE;
            3'b110:  return CF_BLTU;
            3'b111:  return CF_BGEU;
            default: return CF_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate extraction; every format is sign-extended from inst[31].
module id_imm_gen
    import id_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_type_t       imm_type,
    output logic [XLEN-1:0] imm
);

    // Format select; a size cast of a signed value replicates the sign bit.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = XLEN'($signed(inst[31:20]));
            IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({inst[31:12], 12'h000}));
            IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_unit.sv
// Decode stage: control decode, register-operand capture, load-use stall and a
// single registered output slot with valid/ready handshakes on both sides.
module id_decode_unit
    import id_decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output id_out_t         out_data
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    imm_type_t   imm_type_s;
    aluop_t      aluop_s;
    cfuop_t      cfuop_s;
    opr_a_sel_t  a_sel_s;
    opr_b_sel_t  b_sel_s;
    wb_sel_t     wb_sel_s;
    logic        rf_we_s;
    logic        dm_en_s;
    logic        reads_rs1_s;
    logic        reads_rs2_s;
    logic        illegal_s;
    logic        hazard_s;
    logic        accept_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] pc4_s;
    id_out_t     next_data_s;
    logic        out_valid_r;
    id_out_t     out_data_r;

    assign opcode_s = in_inst[6:0];
    assign funct3_s = in_inst[14:12];
    assign rd_s     = in_inst[11:7];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    // Control decode; the opcode compare includes inst[1:0], so compressed encodings land in default.
    always_comb begin
        imm_type_s  = IMM_NONE;
        aluop_s     = ALU_ADD;
        cfuop_s     = CF_NONE;
        a_sel_s     = OPA_RS1;
        b_sel_s     = OPB_RS2;
        wb_sel_s    = WB_ALU;
        rf_we_s     = 1'b0;
        dm_en_s     = 1'b0;
        reads_rs1_s = 1'b0;
        reads_rs2_s = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                imm_type_s = IMM_U; rf_we_s = 1'b1; a_sel_s = OPA_ZERO; b_sel_s = OPB_IMM;
            end
            OPC_AUIPC: begin
                imm_type_s = IMM_U; rf_we_s = 1'b1; a_sel_s = OPA_PC; b_sel_s = OPB_IMM;
            end
            OPC_JAL: begin
                imm_type_s = IMM_J; rf_we_s = 1'b1; cfuop_s = CF_JAL;
                a_sel_s = OPA_PC; b_sel_s = OPB_IMM; wb_sel_s = WB_PC4;
            end
            OPC_JALR: begin
                imm_type_s = IMM_I; rf_we_s = 1'b1; cfuop_s = CF_JALR; reads_rs1_s = 1'b1;
                b_sel_s = OPB_IMM; wb_sel_s = WB_PC4;
            end
            OPC_BRANCH: begin
                imm_type_s = IMM_B; cfuop_s = branch_decode(funct3_s);
                reads_rs1_s = 1'b1; reads_rs2_s = 1'b1; a_sel_s = OPA_PC; b_sel_s = OPB_IMM;
            end
            OPC_LOAD: begin
                imm_type_s = IMM_I; rf_we_s = 1'b1; dm_en_s = 1'b1; reads_rs1_s = 1'b1;
                b_sel_s = OPB_IMM; wb_sel_s = WB_MEM;
            end
            OPC_STORE: begin
                imm_type_s = IMM_S; dm_en_s = 1'b1; reads_rs1_s = 1'b1; reads_rs2_s = 1'b1;
                b_sel_s = OPB_IMM;
            end
            OPC_OP_IMM: begin
                imm_type_s = IMM_I; rf_we_s = 1'b1; reads_rs1_s = 1'b1; b_sel_s = OPB_IMM;
                aluop_s = alu_op_decode(funct3_s, 1'b0, in_inst[30]);
            end
            OPC_OP: begin
                rf_we_s = 1'b1; reads_rs1_s = 1'b1; reads_rs2_s = 1'b1;
                aluop_s = alu_op_decode(funct3_s, in_inst[30], in_inst[30]);
            end
            default: illegal_s = 1'b1;
        endcase
    end

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (in_inst[31:7]),
        .imm_type (imm_type_s),
        .imm      (imm_s)
    );

    assign pc4_s = in_pc + XLEN'(32'd4);

    // Only rs fields the opcode really reads can collide with a load still in EX.
    assign hazard_s = LOAD_USE_STALL && in_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((reads_rs1_s && (rs1_addr == ex_rd)) ||
                       (reads_rs2_s && (rs2_addr == ex_rd)));

    assign in_ready = (!out_valid_r || out_ready) && !hazard_s && !flush;
    assign accept_s = in_valid && in_ready;

    // Payload assembly; x0 reads as zero regardless of the register file.
    always_comb begin
        next_data_s           = '0;
        next_data_s.rd        = rd_s;
        next_data_s.opr_a     = (rs1_addr == 5'd0) ? '0 : DATA_W'(rs1_data);
        next_data_s.opr_b     = (rs2_addr == 5'd0) ? '0 : DATA_W'(rs2_data);
        next_data_s.imm       = DATA_W'(imm_s);
        next_data_s.pc        = DATA_W'(in_pc);
        next_data_s.pc4       = DATA_W'(pc4_s);
        next_data_s.aluop     = aluop_s;
        next_data_s.cfuop     = cfuop_s;
        next_data_s.rf_en     = rf_we_s && (rd_s != 5'd0);
        next_data_s.dm_en     = dm_en_s;
        next_data_s.opr_a_sel = a_sel_s;
        next_data_s.opr_b_sel = b_sel_s;
        next_data_s.wb_sel    = wb_sel_s;
        next_data_s.illegal   = illegal_s;
    end

    // Output slot: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= next_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
